// File: rtl/red_pkg.sv
// Shared types and defaults for the red_seq multi-cycle lane reduction unit.
// The optional saturating lane mode is compiled in with RED_SAT_EN.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } red_state_e;

    localparam int RED_WIDTH         = 16;
    localparam int RED_LANE_W        = 4;
    localparam int RED_LANES_PER_CYC = 1;

    // Number of accumulate cycles needed to cover every lane pair.
    function automatic int red_ngrp(input int width, input int lane_w, input int lanes_per_cyc);
        return (width / lane_w) / lanes_per_cyc;
    endfunction

endpackage

// File: rtl/red_lane_add.sv
// Single lane-pair adder; with RED_SAT_EN the sum clamps to the lane maximum
// when the latched sat flag is set.
module red_lane_add
    import red_pkg::*;
#(
    parameter int LANE_W = RED_LANE_W
) (
    input  logic [LANE_W-1:0] a,
    input  logic [LANE_W-1:0] b,
`ifdef RED_SAT_EN
    input  logic              sat,
`endif
    output logic [LANE_W:0]   s
);

    logic [LANE_W:0] raw;

    assign raw = {1'b0, a} + {1'b0, b};

`ifdef RED_SAT_EN
    assign s = (sat && raw[LANE_W]) ? {1'b0, {LANE_W{1'b1}}} : raw;
`else
    assign s = raw;
`endif

endmodule

// File: rtl/red_seq.sv
// Multi-cycle lane-pair reduction with valid/ready handshakes on both sides.
// Optional saturating lane mode (and the sat port) enabled by RED_SAT_EN.
//
// state | meaning
// IDLE  | in_ready high, waiting for operands
// ACCUM | summing LANES_PER_CYC lane pairs per cycle into acc
// DONE  | out_valid high, Out/ovf held until out_ready
module red_seq
    import red_pkg::*;
#(
    parameter int WIDTH         = RED_WIDTH,
    parameter int LANE_W        = RED_LANE_W,
    parameter int LANES_PER_CYC = RED_LANES_PER_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
`ifdef RED_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             ovf
);

    localparam int NLANES = WIDTH / LANE_W;
    localparam int NGRP   = red_ngrp(WIDTH, LANE_W, LANES_PER_CYC);
    localparam int IDX_W  = $clog2(NLANES + 1);
    localparam int GRP_W  = LANE_W * LANES_PER_CYC;
    // acc plus one group sum is always below 2^(WIDTH+2)
    localparam int SUM_W  = WIDTH + 2;

    red_state_e       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic [LANE_W:0]  lane_s [LANES_PER_CYC];
    logic [SUM_W-1:0] grp_sum;
    logic [SUM_W-1:0] acc_next;
    logic             last_grp;
`ifdef RED_SAT_EN
    logic             sat_q;
`endif

    // Operands shift down each cycle so the current group always sits at the LSBs.
    for (genvar j = 0; j < LANES_PER_CYC; j++) begin : g_lane
        red_lane_add #(.LANE_W(LANE_W)) u_add (
            .a   (a_q[j*LANE_W +: LANE_W]),
            .b   (b_q[j*LANE_W +: LANE_W]),
`ifdef RED_SAT_EN
            .sat (sat_q),
`endif
            .s   (lane_s[j])
        );
    end

    always_comb begin
        grp_sum = '0;
        for (int j = 0; j < LANES_PER_CYC; j++) begin
            grp_sum = grp_sum + SUM_W'(lane_s[j]);
        end
    end

    assign acc_next  = SUM_W'(acc) + grp_sum;
    assign last_grp  = (idx == IDX_W'(NLANES - LANES_PER_CYC));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            idx   <= '0;
            Out   <= '0;
            ovf   <= 1'b0;
`ifdef RED_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= In1;
                        b_q   <= In2;
`ifdef RED_SAT_EN
                        sat_q <= sat;
`endif
                        acc   <= '0;
                        idx   <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next[WIDTH-1:0];
                    a_q <= a_q >> GRP_W;
                    b_q <= b_q >> GRP_W;
                    idx <= idx + IDX_W'(LANES_PER_CYC);
                    if (|acc_next[SUM_W-1:WIDTH]) begin
                        ovf <= 1'b1;
                    end
                    if (last_grp) begin
                        Out   <= acc_next[WIDTH-1:0];
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_red_seq.sv
// Directed bench for red_seq: default, 8-bit single-lane, and wider-per-cycle builds.
// Saturating checks are included when RED_SAT_EN is defined.
module tb_red_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ordy = 1'b1;
    logic [15:0] a16 = '0;
    logic [15:0] b16 = '0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
`ifdef RED_SAT_EN
    logic        sat = 1'b0;
`endif

    logic        iv0 = 1'b0, iv2 = 1'b0, iv4 = 1'b0, iv8 = 1'b0;
    logic        ir0, ir2, ir4, ir8;
    logic        ov0, ov2, ov4, ov8;
    logic        ovf0, ovf2, ovf4, ovf8;
    logic [15:0] out0, out2, out4;
    logic [7:0]  out8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    red_seq u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .In1(a16), .In2(b16),
`ifdef RED_SAT_EN
        .sat(sat),
`endif
        .out_valid(ov0), .out_ready(ordy), .Out(out0), .ovf(ovf0)
    );

    red_seq #(.WIDTH(16), .LANE_W(4), .LANES_PER_CYC(2)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .In1(a16), .In2(b16),
`ifdef RED_SAT_EN
        .sat(sat),
`endif
        .out_valid(ov2), .out_ready(ordy), .Out(out2), .ovf(ovf2)
    );

    red_seq #(.WIDTH(16), .LANE_W(4), .LANES_PER_CYC(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .In1(a16), .In2(b16),
`ifdef RED_SAT_EN
        .sat(sat),
`endif
        .out_valid(ov4), .out_ready(ordy), .Out(out4), .ovf(ovf4)
    );

    red_seq #(.WIDTH(8), .LANE_W(8), .LANES_PER_CYC(1)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .In1(a8), .In2(b8),
`ifdef RED_SAT_EN
        .sat(sat),
`endif
        .out_valid(ov8), .out_ready(ordy), .Out(out8), .ovf(ovf8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full operation on the default instance with out_ready held high.
    task automatic run0(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp);
        a16 = a;
        b16 = b;
        iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        chk({tag, " in_ready after accept"}, 32'(ir0), 32'd0);
        repeat (3) begin
            step();
            chk({tag, " out_valid early"}, 32'(ov0), 32'd0);
        end
        step();
        chk({tag, " out_valid"}, 32'(ov0), 32'd1);
        chk({tag, " Out"}, 32'(out0), 32'(exp));
        chk({tag, " ovf"}, 32'(ovf0), 32'd0);
        step();
        chk({tag, " out_valid after consume"}, 32'(ov0), 32'd0);
        chk({tag, " in_ready after consume"}, 32'(ir0), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset Out", 32'(out0), 32'd0);
        chk("reset ovf", 32'(ovf0), 32'd0);
        rst = 1'b0;

        run0("lanes4646", 16'h4646, 16'h6464, 16'h0028);
        run0("small", 16'h0009, 16'h0006, 16'h000F);
        run0("wrap", 16'h7979, 16'h9797, 16'h0040);
`ifdef RED_SAT_EN
        sat = 1'b1;
        run0("sat", 16'h7979, 16'h9797, 16'h003C);
        sat = 1'b0;
`endif

        // Output stall in DONE: new operands must be ignored.
        ordy = 1'b0;
        a16 = 16'h4646;
        b16 = 16'h6464;
        iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        repeat (4) step();
        chk("stall enter valid", 32'(ov0), 32'd1);
        chk("stall enter Out", 32'(out0), 32'h0028);
        a16 = 16'hFFFF;
        b16 = 16'hFFFF;
        iv0 = 1'b1;
        repeat (5) begin
            step();
            chk("stall out_valid", 32'(ov0), 32'd1);
            chk("stall Out", 32'(out0), 32'h0028);
            chk("stall in_ready", 32'(ir0), 32'd0);
            chk("stall ovf", 32'(ovf0), 32'd0);
        end
        iv0 = 1'b0;
        ordy = 1'b1;
        step();
        chk("release out_valid", 32'(ov0), 32'd0);
        chk("release in_ready", 32'(ir0), 32'd1);
        chk("release Out held", 32'(out0), 32'h0028);
        step();
        chk("idle stays idle", 32'(ir0), 32'd1);

        // Reset mid-ACCUM after two edges.
        a16 = 16'h4646;
        b16 = 16'h6464;
        iv0 = 1'b1;
        step();
        iv0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("abort in_ready", 32'(ir0), 32'd1);
        chk("abort out_valid", 32'(ov0), 32'd0);
        chk("abort Out", 32'(out0), 32'd0);
        rst = 1'b0;
        run0("after abort", 16'h0009, 16'h0006, 16'h000F);

        // 8-bit single lane: carry out of the accumulator.
        a8 = 8'hFF;
        b8 = 8'h01;
        iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        chk("w8 in_ready drop", 32'(ir8), 32'd0);
        step();
        chk("w8 out_valid", 32'(ov8), 32'd1);
        chk("w8 Out", 32'(out8), 32'h00);
        chk("w8 ovf set", 32'(ovf8), 32'd1);
        step();
        chk("w8 consumed", 32'(ov8), 32'd0);
        chk("w8 ovf sticky", 32'(ovf8), 32'd1);
        a8 = 8'h01;
        b8 = 8'h01;
        iv8 = 1'b1;
        step();
        iv8 = 1'b0;
        chk("w8 ovf cleared on accept", 32'(ovf8), 32'd0);
        step();
        chk("w8 second out_valid", 32'(ov8), 32'd1);
        chk("w8 second Out", 32'(out8), 32'h02);
        chk("w8 second ovf", 32'(ovf8), 32'd0);
        step();

        // Two lanes per cycle.
        a16 = 16'h4646;
        b16 = 16'h6464;
        iv2 = 1'b1;
        step();
        iv2 = 1'b0;
        step();
        chk("lpc2 early", 32'(ov2), 32'd0);
        step();
        chk("lpc2 out_valid", 32'(ov2), 32'd1);
        chk("lpc2 Out", 32'(out2), 32'h0028);
        step();

        // Four lanes per cycle.
        iv4 = 1'b1;
        step();
        iv4 = 1'b0;
        chk("lpc4 in_ready drop", 32'(ir4), 32'd0);
        step();
        chk("lpc4 out_valid", 32'(ov4), 32'd1);
        chk("lpc4 Out", 32'(out4), 32'h0028);
        step();
        chk("lpc4 consumed", 32'(ov4), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/red_seq.md
# red_seq

Multi-cycle, parametrised successor to the single-cycle 16-bit reduction unit in the execute stage. It splits two WIDTH-bit operands into LANE_W-bit unsigned lanes and adds each lane pair. All lane sums are accumulated into one WIDTH-bit result over several cycles. The operand and result ports use valid/ready handshakes so the block can stall the pipeline or share an issue slot. An optional per-lane saturating mode is compiled in by macro.

## Interface
- WIDTH, 16, operand/result width
- LANE_W, 4, lane width; WIDTH % LANE_W == 0
- LANES_PER_CYC, 1, lane pairs reduced per cycle; NLANES = WIDTH/LANE_W, NLANES % LANES_PER_CYC == 0
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands offered
- in_ready  out  1  block can accept operands
- In1  in  WIDTH  operand A
- In2  in  WIDTH  operand B
- sat  in  1  saturating lane mode; present only with RED_SAT_EN
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- Out  out  WIDTH  reduction result
- ovf  out  1  accumulator carried out of WIDTH bits during this operation

## Operation
- States: IDLE, ACCUM, DONE (enum in package).
- Reset values: state=IDLE, in_ready=1, out_valid=0, Out=0, ovf=0, lane index=0.
- IDLE:
  - in_ready=1.
  - On in_valid: latch In1, In2 and sat; clear acc, index and ovf; go to ACCUM.
- ACCUM:
  - in_ready=0.
  - Each cycle processes lanes idx..idx+LANES_PER_CYC-1, lane 0 = LSBs.
  - s_i = a_i + b_i, LANE_W+1 bits, zero-extended.
  - Accumulate acc += Σ s_i, modulo 2^WIDTH.
  - A carry out of bit WIDTH-1 sets ovf (sticky).
  - idx += LANES_PER_CYC.
  - After the last group: load Out with the final acc and go to DONE.
- DONE:
  - out_valid=1; Out and ovf held stable.
  - On out_ready: go to IDLE, out_valid=0.
  - Out and ovf keep their value until the next DONE load.
- In1, In2 and sat are ignored outside the IDLE accept cycle.
- in_ready is asserted only in IDLE. There is no accept in DONE, even if out_ready is high; back-to-back operations cost one IDLE cycle.
- Asserting rst in any state aborts the operation, discards latched operands, and restores the reset values on the next evaluation (asynchronous).
- ovf is cleared only on accept or reset, never on output handshake.

## Timing
- NGRP = NLANES/LANES_PER_CYC.
- Accept on edge 0 (in_valid & in_ready).
- out_valid rises after edge NGRP. Default: 4 cycles.
- A result is consumed on the edge where out_valid & out_ready.
- in_ready returns the cycle after that edge, so minimum initiation interval = NGRP+2 cycles.
- out_ready held high before DONE has no effect until out_valid is asserted.
- Out changes only on the DONE-entry edge, or on reset.

## Configuration
- RED_SAT_EN defined:
  - The sat port exists.
  - When the latched sat=1, each s_i saturates to 2^LANE_W−1 instead of LANE_W+1 bits.
  - When the latched sat=0, behaviour matches the wrapping mode below.
- RED_SAT_EN undefined:
  - No sat port; wrapping lane sums only.
  - Saturation logic is absent.

## Structure
- Package red_pkg:
  - state enum type (IDLE/ACCUM/DONE).
  - Default parameter constants.
  - Function computing NGRP.
- Sub-module red_lane_add:
  - One lane pair add with optional saturation (guarded by RED_SAT_EN).
  - Instantiated LANES_PER_CYC times; their outputs are summed into acc.
- Top level holds the FSM, operand registers, index counter, accumulator, Out and ovf.

## Test plan
- Default params, In1=0x4646, In2=0x6464, out_ready=1 → in_ready drops after accept, out_valid after 4 edges, Out=0x0028, ovf=0.
- In1=0x0009, In2=0x0006 → Out=0x000F. In1=0x7979, In2=0x9797, wrapping → Out=0x0040; with RED_SAT_EN and sat=1 → Out=0x003C.
- WIDTH=8, LANE_W=8, In1=0xFF, In2=0x01 → Out=0x00, ovf=1. Next operation 0x01+0x01 → Out=0x02, ovf=0.
- out_ready=0 for 5 cycles in DONE → out_valid stays 1, Out stable, in_ready=0, new in_valid ignored. out_ready=1 → IDLE next cycle.
- rst pulsed mid-ACCUM (after 2 edges) → out_valid=0, Out=0, in_ready=1 immediately. The following 0x0009+0x0006 gives 0x000F after 4 edges.
- LANES_PER_CYC=2, In1=0x4646, In2=0x6464 → Out=0x0028 after 2 edges. LANES_PER_CYC=4 → after 1 edge.
